// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: the sign-injection op encoding and the
// single-precision word type used across the FPU blocks.
package fpu_pkg;

  typedef enum logic [1:0] {
    FSGN_J   = 2'b00,
    FSGN_JN  = 2'b01,
    FSGN_JX  = 2'b10,
    FSGN_ILL = 2'b11
  } fsgn_op_e;

  typedef logic [31:0] float_t;

endpackage : fpu_pkg

// File: rtl/fsgn_core.sv
// Combinational sign-injection datapath: the magnitude always comes from x1,
// and the op selects where the sign comes from.
module fsgn_core
  import fpu_pkg::*;
(
  input  float_t   x1,
  input  float_t   x2,
  input  fsgn_op_e op,
  output float_t   y,
  output logic     err
);

  // NOTE: every output gets a default before the case, so no path through
  // this block can leave y or err unassigned and infer a latch.
  always_comb begin
    y   = x1;
    err = 1'b0;
    unique case (op)
      FSGN_J:   y = {x2[31], x1[30:0]};
      FSGN_JN:  y = {~x2[31], x1[30:0]};
      FSGN_JX:  y = {x1[31] ^ x2[31], x1[30:0]};
      FSGN_ILL: err = 1'b1;
    endcase
  end

endmodule : fsgn_core

// File: rtl/fsgn_sched.sv
// Two-requester round-robin front end for one shared sign-injection unit,
// with a single result register that drains and reloads in the same cycle.
module fsgn_sched
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [63:0]        req_x1,
  input  logic [63:0]        req_x2,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [TAG_W-1:0]   resp_tag,
  output logic [31:0]        resp_y,
  output logic               resp_err
);

  logic       free;
  logic       gnt_vld;
  logic       gnt_idx;
  logic       rr;
  float_t     sel_x1;
  float_t     sel_x2;
  fsgn_op_e   sel_op;
  float_t     core_y;
  logic       core_err;

  // Grant while the register is empty or being drained this cycle; reset
  // blocks any transfer so a held request cannot slip through.
  always_comb begin
    free      = ~resp_valid | resp_ready;
    gnt_vld   = ~rst & free & (|req_valid);
    gnt_idx   = (req_valid == 2'b11) ? rr : req_valid[1];
    req_ready = 2'b00;
    if (gnt_vld) req_ready = gnt_idx ? 2'b10 : 2'b01;
    sel_x1    = gnt_idx ? req_x1[63:32] : req_x1[31:0];
    sel_x2    = gnt_idx ? req_x2[63:32] : req_x2[31:0];
    sel_op    = fsgn_op_e'(gnt_idx ? req_op[3:2] : req_op[1:0]);
  end

  fsgn_core u_core (
    .x1  (sel_x1),
    .x2  (sel_x2),
    .op  (sel_op),
    .y   (core_y),
    .err (core_err)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_tag   <= '0;
      resp_y     <= '0;
      resp_err   <= 1'b0;
      rr         <= 1'b0;
    end else if (gnt_vld) begin
      resp_valid <= 1'b1;
      resp_id    <= gnt_idx;
      resp_tag   <= gnt_idx ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
      resp_y     <= core_y;
      resp_err   <= core_err;
      rr         <= ~gnt_idx;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule : fsgn_sched

// File: tb/tb_fsgn_sched.sv
// Directed bench for fsgn_sched: inputs change on the falling edge, req_ready
// is checked before the rising edge and the result register 1 ns after it.
module tb_fsgn_sched;

  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req_op;
  logic [63:0]        req_x1;
  logic [63:0]        req_x2;
  logic [2*TAG_W-1:0] req_tag;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_id;
  logic [TAG_W-1:0]   resp_tag;
  logic [31:0]        resp_y;
  logic               resp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsgn_sched #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x1     (req_x1),
    .req_x2     (req_x2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_tag   (resp_tag),
    .resp_y     (resp_y),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [TAG_W-1:0] tag);
    if (idx == 0) begin
      req_op[1:0] = op; req_x1[31:0] = x1; req_x2[31:0] = x2; req_tag[TAG_W-1:0] = tag;
    end else begin
      req_op[3:2] = op; req_x1[63:32] = x1; req_x2[63:32] = x2; req_tag[2*TAG_W-1:TAG_W] = tag;
    end
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic v, input logic id,
                            input logic [TAG_W-1:0] t, input logic [31:0] y, input logic e);
    check({tag, ".valid"}, {31'd0, resp_valid}, {31'd0, v});
    check({tag, ".id"},    {31'd0, resp_id},    {31'd0, id});
    check({tag, ".tag"},   {28'd0, resp_tag},   {28'd0, t});
    check({tag, ".y"},     resp_y,              y);
    check({tag, ".err"},   {31'd0, resp_err},   {31'd0, e});
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    req_op = '0; req_x1 = '0; req_x2 = '0; req_tag = '0;

    // Reset state: nothing granted even with both requesters valid.
    after_rise();
    check("rst.req_ready", {30'd0, req_ready}, 32'd0);
    check_resp("rst", 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single sgnj request from requester 0.
    req_valid = 2'b01;
    set_req(0, 2'b00, 32'h3F80_0000, 32'h8000_0000, 4'd5);
    #1 check("sgnj.req_ready", {30'd0, req_ready}, 32'd1);
    after_rise();
    check_resp("sgnj", 1'b1, 1'b0, 4'd5, 32'hBF80_0000, 1'b0);

    // Illegal op from requester 1 alone; pointer moves back to 0.
    @(negedge clk);
    req_valid = 2'b10;
    set_req(1, 2'b11, 32'h1234_5678, 32'hFFFF_FFFF, 4'd3);
    #1 check("ill.req_ready", {30'd0, req_ready}, 32'd2);
    after_rise();
    check_resp("ill", 1'b1, 1'b1, 4'd3, 32'h1234_5678, 1'b1);

    // Both valid for 4 cycles: grants alternate 0,1,0,1, one result per cycle.
    @(negedge clk);
    req_valid = 2'b11;
    set_req(0, 2'b10, 32'hC000_0000, 32'h8000_0000, 4'd1);
    set_req(1, 2'b01, 32'h4000_0000, 32'h0000_0000, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("rr%0d.req_ready", i), {30'd0, req_ready},
               (i % 2 == 0) ? 32'd1 : 32'd2);
      after_rise();
      if (i % 2 == 0) check_resp($sformatf("rr%0d", i), 1'b1, 1'b0, 4'd1, 32'h4000_0000, 1'b0);
      else            check_resp($sformatf("rr%0d", i), 1'b1, 1'b1, 4'd2, 32'hC000_0000, 1'b0);
      @(negedge clk);
    end

    // Backpressure for 3 cycles: no grants, held result stays put.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("stall%0d.req_ready", i), {30'd0, req_ready}, 32'd0);
      after_rise();
      check_resp($sformatf("stall%0d", i), 1'b1, 1'b1, 4'd2, 32'hC000_0000, 1'b0);
      @(negedge clk);
    end

    // Release: drain and new grant (pointer at 0) in the same cycle.
    resp_ready = 1'b1;
    #1 check("drain.req_ready", {30'd0, req_ready}, 32'd1);
    after_rise();
    check_resp("drain", 1'b1, 1'b0, 4'd1, 32'h4000_0000, 1'b0);

    // Dropped requests: consumer ready, no grant, register empties.
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("idle.req_ready", {30'd0, req_ready}, 32'd0);
    after_rise();
    check("idle.valid", {31'd0, resp_valid}, 32'd0);

    // Load a result (pointer ends at 1), then reset between edges.
    @(negedge clk);
    req_valid  = 2'b01;
    resp_ready = 1'b0;
    after_rise();
    check("prerst.valid", {31'd0, resp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_resp("midrst", 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    check("midrst.req_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    #1 check("postrst.req_ready", {30'd0, req_ready}, 32'd1);
    after_rise();
    check_resp("postrst", 1'b1, 1'b0, 4'd1, 32'h4000_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fsgn_sched
